endeavour_cmd_rx: RTL and testbench
===================================

ENDEAVOUR_CMD_RX -- requirements
Module: endeavour_cmd_rx

Interface
REQ-001 SHALL have parameter DIT_MIN, default 6: minimum high-pulse length in bclk cycles decoded as bit 0.
REQ-002 SHALL have parameter DIT_MAX, default 22: maximum high-pulse length decoded as bit 0.
REQ-003 SHALL have parameter DAH_MIN, default 29: minimum high-pulse length decoded as bit 1.
REQ-004 SHALL have parameter DAH_MAX, default 124: maximum high-pulse length decoded as bit 1.
REQ-005 SHALL have parameter EOF_CNT, default 200: number of consecutive low cycles that ends a frame.
REQ-006 SHALL have port bclk, input, 1: clock; all logic runs on the rising edge.
REQ-007 SHALL have port rstb, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port cmd_in, input, 1: asynchronous serial command line, idle low.
REQ-009 SHALL have port addrOut, output, 8: register address of the last accepted write.
REQ-010 SHALL have port dataOut, output, 32: data of the last accepted write.
REQ-011 SHALL have port latchOut, output, 1: single-cycle write strobe for downstream monitor registers.
REQ-012 SHALL have port errOut, output, 1: single-cycle pulse on a discarded frame.

Function
REQ-013 SHALL synchronise cmd_in through two flops before any use.
REQ-014 SHALL measure each high pulse with an 8-bit counter that saturates at 255.
REQ-015 SHALL classify a pulse on its falling edge: DIT_MIN..DIT_MAX -> 0, DAH_MIN..DAH_MAX -> 1, any other length -> frame error.
REQ-016 SHALL shift decoded bits in MSB first: cmd[7:0], addr[7:0], data[31:0], then crc[7:0].
REQ-017 SHALL use FSM states IDLE, HIGH, LOW and DRAIN.
REQ-018 SHALL perform these transitions:
- IDLE->HIGH on a synced rising edge.
- HIGH->LOW on a falling edge with a valid pulse.
- HIGH->DRAIN on an invalid pulse.
- LOW->HIGH on a rising edge before EOF_CNT.
- LOW->IDLE after EOF_CNT low cycles, with frame evaluation.
- DRAIN->IDLE after EOF_CNT low cycles.
REQ-019 SHALL accept a frame only when the bit count is exactly the expected count, cmd equals 8'hC3 (WRITE) and the CRC, if enabled, matches.
REQ-020 SHALL, on an accepted frame, load addrOut and dataOut and pulse latchOut high for exactly one bclk cycle, in the same cycle the outputs update.
REQ-021 SHALL time the latchOut pulse as the (EOF_CNT+3)th rising edge after the synchronised falling edge of the last pulse.
REQ-022 SHALL hold addrOut and dataOut stable between accepted frames, so a negedge consumer sees a settled strobe.
REQ-023 SHALL treat a correct-length frame with correct CRC and cmd not 8'hC3 as a silent ignore: no latchOut and no errOut.
REQ-024 SHALL pulse errOut once, at the end-of-frame timing, for a wrong bit count, an invalid pulse or a CRC mismatch.
REQ-025 SHALL discard the frame after an invalid pulse; later pulses in DRAIN SHALL restart the low-cycle count and SHALL NOT emit further errOut.
REQ-026 SHALL discard a frame longer than the expected bit count: extra bits SHALL stop shifting and set the error flag.
REQ-027 SHALL treat a pulse still high at 255 cycles as invalid, and SHALL stay in DRAIN until the line has been low for EOF_CNT cycles.

Reset
REQ-028 SHALL asynchronously set, on rstb low: FSM to IDLE; addrOut=0, dataOut=0, latchOut=0, errOut=0; counters, shift register, CRC and sync flops to 0.
REQ-029 SHALL discard a frame in progress when rstb asserts, with no latchOut.
REQ-030 SHALL require a fresh rising edge on cmd_in after rstb deasserts before starting a frame.

Configuration
REQ-031 SHALL, with ENDEAVOUR_CRC_EN defined, expect 56 bits per frame and check CRC-8 (poly 8'h07, init 8'h00, MSB first) over the first 48 bits against crc[7:0].
REQ-032 SHALL, without ENDEAVOUR_CRC_EN, expect 48 bits per frame, instantiate no CRC logic and never raise errOut for a CRC reason.

Structure
REQ-033 SHALL take the WRITE command code, CRC polynomial, frame bit counts and FSM state encoding from shared package endeavour_pkg.
REQ-034 SHALL place the synchroniser, pulse counter and classifier in sub-module endeavour_bitrx, which outputs bit_valid, bit_val and bit_err.

Verification
REQ-035 SHALL be verified for a valid WRITE with addr 8'h2A, data 32'hCCCC9999 and correct CRC: one latchOut at EOF_CNT+3 cycles, addrOut=8'h2A, dataOut=32'hCCCC9999.
REQ-036 SHALL be verified for the same frame with its CRC LSB flipped: no latchOut, one errOut, outputs unchanged.
REQ-037 SHALL be verified for a 25-cycle pulse mid-frame: no latchOut, exactly one errOut; a following valid frame SHALL be accepted.
REQ-038 SHALL be verified for a 55-bit frame and a 57-bit frame: one errOut each, no latchOut.
REQ-039 SHALL be verified for cmd 8'h5A with a valid CRC: neither latchOut nor errOut.
REQ-040 SHALL be verified for rstb asserted after 30 bits, then released: outputs 0, no strobe; the next full frame SHALL be accepted.

Source files
------------

// File: rtl/endeavour_pkg.sv
// Shared constants, FSM encoding and CRC-8 step for the Endeavour command receiver.
// Frame length depends on ENDEAVOUR_CRC_EN (56 bits with CRC, 48 without).
package endeavour_pkg;

  localparam logic [7:0]  CmdWrite    = 8'hC3;
  localparam logic [7:0]  CrcPoly     = 8'h07;
  localparam int unsigned PayloadBits = 48;
`ifdef ENDEAVOUR_CRC_EN
  localparam int unsigned CrcBits     = 8;
`else
  localparam int unsigned CrcBits     = 0;
`endif
  localparam int unsigned FrameBits   = PayloadBits + CrcBits;

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StDrain} rx_state_e;

  // One MSB-first serial step of CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CrcPoly : 8'h00);
  endfunction

endpackage

// File: rtl/endeavour_bitrx.sv
// Line synchroniser, high-pulse length counter and dit/dah classifier.
// All event outputs are registered so they stay ordered with each other.
module endeavour_bitrx #(
  parameter int unsigned DIT_MIN = 6,
  parameter int unsigned DIT_MAX = 22,
  parameter int unsigned DAH_MIN = 29,
  parameter int unsigned DAH_MAX = 124
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cmd_i,
  output logic rise_o,
  output logic line_o,
  output logic bit_valid_o,
  output logic bit_val_o,
  output logic bit_err_o
);

  localparam logic [7:0] DitMin = 8'(DIT_MIN);
  localparam logic [7:0] DitMax = 8'(DIT_MAX);
  localparam logic [7:0] DahMin = 8'(DAH_MIN);
  localparam logic [7:0] DahMax = 8'(DAH_MAX);

  logic       s1_q, s2_q, s3_q;
  logic [7:0] cnt_q, cnt_d;
  logic       rise_q, valid_q, val_q, err_q;
  logic       fall, is_dit, is_dah, long_pulse;

  assign fall   = s3_q & ~s2_q;
  assign is_dit = (cnt_q >= DitMin) && (cnt_q <= DitMax);
  assign is_dah = (cnt_q >= DahMin) && (cnt_q <= DahMax);
  // Fires once as the counter saturates while the line is still high.
  assign long_pulse = s2_q && (cnt_q == 8'hFE);

  always_comb begin
    cnt_d = 8'd0;
    if (s2_q) cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rise_q  <= 1'b0;
      valid_q <= 1'b0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= cmd_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_q   <= cnt_d;
      rise_q  <= s2_q & ~s3_q;
      valid_q <= fall & (is_dit | is_dah);
      val_q   <= is_dah;
      err_q   <= (fall & ~(is_dit | is_dah)) | long_pulse;
    end
  end

  assign rise_o      = rise_q;
  assign line_o      = s3_q;
  assign bit_valid_o = valid_q;
  assign bit_val_o   = val_q;
  assign bit_err_o   = err_q;

endmodule

// File: rtl/endeavour_cmd_rx.sv
// Endeavour serial command receiver: decodes WRITE frames into addrOut/dataOut + latchOut.
// Define ENDEAVOUR_CRC_EN to expect and check a trailing CRC-8 byte.
module endeavour_cmd_rx
  import endeavour_pkg::*;
#(
  parameter int unsigned DIT_MIN = 6,
  parameter int unsigned DIT_MAX = 22,
  parameter int unsigned DAH_MIN = 29,
  parameter int unsigned DAH_MAX = 124,
  parameter int unsigned EOF_CNT = 200
) (
  input  logic        bclk,
  input  logic        rstb,
  input  logic        cmd_in,
  output logic [7:0]  addrOut,
  output logic [31:0] dataOut,
  output logic        latchOut,
  output logic        errOut
);

  localparam logic [15:0] EofCnt   = 16'(EOF_CNT);
  localparam logic [6:0]  FrameLen = 7'(FrameBits);

  logic                 rise, line, bit_valid, bit_val, bit_err;
  rx_state_e            state_q, state_d;
  logic [FrameBits-1:0] shreg_q, shreg_d;
  logic [6:0]           bit_cnt_q, bit_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          low_cnt_q, low_cnt_d;
  logic                 eof, crc_bad, frame_bad, latch_d, err_d;
  logic [7:0]           addr_q;
  logic [31:0]          data_q;
  logic                 latch_q, err_q;
  logic [7:0]           frm_cmd, frm_addr;
  logic [31:0]          frm_data;

  endeavour_bitrx #(
    .DIT_MIN(DIT_MIN),
    .DIT_MAX(DIT_MAX),
    .DAH_MIN(DAH_MIN),
    .DAH_MAX(DAH_MAX)
  ) u_bitrx (
    .clk_i      (bclk),
    .rst_ni     (rstb),
    .cmd_i      (cmd_in),
    .rise_o     (rise),
    .line_o     (line),
    .bit_valid_o(bit_valid),
    .bit_val_o  (bit_val),
    .bit_err_o  (bit_err)
  );

  assign frm_cmd  = shreg_q[FrameBits-1 -: 8];
  assign frm_addr = shreg_q[FrameBits-9 -: 8];
  assign frm_data = shreg_q[FrameBits-17 -: 32];
  assign eof      = (low_cnt_q == EofCnt);

`ifdef ENDEAVOUR_CRC_EN
  localparam logic [6:0] PayloadLen = 7'(PayloadBits);
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == StIdle && rise) begin
      crc_d = 8'h00;
    end else if (state_q == StHigh && bit_valid && bit_cnt_q < PayloadLen) begin
      crc_d = crc8_step(crc_q, bit_val);
    end
  end

  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) crc_q <= 8'h00;
    else       crc_q <= crc_d;
  end

  assign crc_bad = (crc_q != shreg_q[7:0]);
`else
  assign crc_bad = 1'b0;
`endif

  assign frame_bad = ovf_q | (bit_cnt_q != FrameLen) | crc_bad;

  // FSM: state register
  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StHigh;
      StHigh: begin
        if (bit_err)        state_d = StDrain;
        else if (bit_valid) state_d = StLow;
      end
      StLow: begin
        if (rise)     state_d = StHigh;
        else if (eof) state_d = StIdle;
      end
      StDrain: if (!rise && eof) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: end-of-frame outputs
  always_comb begin
    latch_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StLow: begin
        if (!rise && eof) begin
          if (frame_bad)                err_d   = 1'b1;
          else if (frm_cmd == CmdWrite) latch_d = 1'b1;
        end
      end
      StDrain: if (!rise && eof) err_d = 1'b1;
      default: ;
    endcase
  end

  // Every pulse end restarts the low count, so LOW and DRAIN time out identically.
  always_comb begin
    low_cnt_d = 16'd0;
    if ((state_q == StLow || state_q == StDrain) && !line && !bit_valid && !bit_err) begin
      low_cnt_d = low_cnt_q + 16'd1;
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ovf_d     = ovf_q;
    if (state_q == StIdle && rise) begin
      shreg_d   = '0;
      bit_cnt_d = 7'd0;
      ovf_d     = 1'b0;
    end else if (state_q == StHigh && bit_valid) begin
      if (bit_cnt_q < FrameLen) begin
        shreg_d   = {shreg_q[FrameBits-2:0], bit_val};
        bit_cnt_d = bit_cnt_q + 7'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge bclk or negedge rstb) begin
    if (!rstb) begin
      shreg_q   <= '0;
      bit_cnt_q <= 7'd0;
      ovf_q     <= 1'b0;
      low_cnt_q <= 16'd0;
      addr_q    <= 8'h00;
      data_q    <= 32'h0;
      latch_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
      low_cnt_q <= low_cnt_d;
      latch_q   <= latch_d;
      err_q     <= err_d;
      if (latch_d) begin
        addr_q <= frm_addr;
        data_q <= frm_data;
      end
    end
  end

  assign addrOut  = addr_q;
  assign dataOut  = data_q;
  assign latchOut = latch_q;
  assign errOut   = err_q;

endmodule

// File: tb/tb_endeavour_cmd_rx.sv
// Directed bench for endeavour_cmd_rx with a scoreboard of expected end-of-frame strobes.
module tb_endeavour_cmd_rx;

  localparam int unsigned EOF      = 200;
  localparam int          DIT_LEN  = 12;
  localparam int          DAH_LEN  = 60;
  localparam int          BAD_LEN  = 25;
  localparam int          GAP      = 8;
`ifdef ENDEAVOUR_CRC_EN
  localparam int          FB       = 56;
`else
  localparam int          FB       = 48;
`endif
  localparam logic [1:0]  K_LATCH  = 2'b10;
  localparam logic [1:0]  K_ERR    = 2'b01;

  typedef struct {
    logic [1:0]  kind;
    logic [7:0]  addr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        bclk = 1'b0;
  logic        rstb = 1'b0;
  logic        cmd_in = 1'b0;
  logic [7:0]  addrOut;
  logic [31:0] dataOut;
  logic        latchOut, errOut;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int unsigned n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0]  mdl_addr = 8'h00;
  logic [31:0] mdl_data = 32'h0;
  logic [63:0] fr;

  endeavour_cmd_rx #(
    .DIT_MIN(6),
    .DIT_MAX(22),
    .DAH_MIN(29),
    .DAH_MAX(124),
    .EOF_CNT(EOF)
  ) dut (
    .bclk    (bclk),
    .rstb    (rstb),
    .cmd_in  (cmd_in),
    .addrOut (addrOut),
    .dataOut (dataOut),
    .latchOut(latchOut),
    .errOut  (errOut)
  );

  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [47:0] p);
    logic [7:0] c = 8'h00;
    for (int i = 47; i >= 0; i--) begin
      logic fb = c[7] ^ p[i];
      c = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [63:0] mk_frame(input logic [7:0] cmd, input logic [7:0] a,
                                           input logic [31:0] d);
    logic [47:0] p = {cmd, a, d};
`ifdef ENDEAVOUR_CRC_EN
    return {8'h00, p, crc8(p)};
`else
    return {16'h0000, p};
`endif
  endfunction

  // Sends bits hi..lo of f as pulses; bit index `bad` gets an out-of-range length.
  task automatic send_bits(input logic [63:0] f, input int hi, input int lo, input int bad);
    for (int i = hi; i >= lo; i--) begin
      cmd_in = 1'b1;
      repeat ((i == bad) ? BAD_LEN : (f[i] ? DAH_LEN : DIT_LEN)) @(negedge bclk);
      cmd_in = 1'b0;
      last_fall = cyc;
      repeat (GAP) @(negedge bclk);
    end
  endtask

  // Strobe due EOF+3 edges after the 2-flop-synchronised fall, i.e. EOF+5 after the drive.
  task automatic expect_evt(input logic [1:0] kind, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.cyc  = last_fall + EOF + 5;
    sb.push_back(e);
    if (kind == K_LATCH) begin
      mdl_addr = a;
      mdl_data = d;
    end
  endtask

  task automatic settle(input string tag);
    repeat (EOF + 20) @(negedge bclk);
    chk({tag, "_pending"}, 64'(sb.size()), 64'd0);
    chk({tag, "_addr"}, 64'(addrOut), 64'(mdl_addr));
    chk({tag, "_data"}, 64'(dataOut), 64'(mdl_data));
    sb.delete();
  endtask

  always @(negedge bclk) begin
    if (rstb && (latchOut || errOut)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'({latchOut, errOut}), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", 64'({latchOut, errOut}), 64'(mon_e.kind));
        chk("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
        if (mon_e.kind == K_LATCH) begin
          chk("strobe_addr", 64'(addrOut), 64'(mon_e.addr));
          chk("strobe_data", 64'(dataOut), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge bclk);
    chk("rst_addr", 64'(addrOut), 64'd0);
    chk("rst_data", 64'(dataOut), 64'd0);
    chk("rst_latch", 64'(latchOut), 64'd0);
    chk("rst_err", 64'(errOut), 64'd0);
    rstb = 1'b1;
    repeat (4) @(negedge bclk);

    fr = mk_frame(8'hC3, 8'h2A, 32'hCCCC9999);
    send_bits(fr, FB - 1, 0, -1);
    expect_evt(K_LATCH, 8'h2A, 32'hCCCC9999);
    settle("valid_a");

`ifdef ENDEAVOUR_CRC_EN
    send_bits(fr ^ 64'd1, FB - 1, 0, -1);
    expect_evt(K_ERR, 8'h00, 32'h0);
    settle("crc_flip");
`endif

    fr = mk_frame(8'hC3, 8'h11, 32'hDEADBEEF);
    send_bits(fr, FB - 1, 0, FB - 20);
    expect_evt(K_ERR, 8'h00, 32'h0);
    settle("bad_pulse");
    send_bits(fr, FB - 1, 0, -1);
    expect_evt(K_LATCH, 8'h11, 32'hDEADBEEF);
    settle("valid_b");

    send_bits(fr >> 1, FB - 2, 0, -1);
    expect_evt(K_ERR, 8'h00, 32'h0);
    settle("short_frame");
    send_bits({fr[62:0], 1'b1}, FB, 0, -1);
    expect_evt(K_ERR, 8'h00, 32'h0);
    settle("long_frame");

    fr = mk_frame(8'h5A, 8'h77, 32'h12345678);
    send_bits(fr, FB - 1, 0, -1);
    settle("cmd_5a");

    cmd_in = 1'b1;
    repeat (300) @(negedge bclk);
    cmd_in = 1'b0;
    last_fall = cyc;
    expect_evt(K_ERR, 8'h00, 32'h0);
    settle("stuck_high");

    fr = mk_frame(8'hC3, 8'h5C, 32'h01234567);
    send_bits(fr, FB - 1, FB - 30, -1);
    rstb = 1'b0;
    @(negedge bclk);
    chk("midrst_addr", 64'(addrOut), 64'd0);
    chk("midrst_data", 64'(dataOut), 64'd0);
    chk("midrst_latch", 64'(latchOut), 64'd0);
    chk("midrst_err", 64'(errOut), 64'd0);
    repeat (2) @(negedge bclk);
    rstb = 1'b1;
    mdl_addr = 8'h00;
    mdl_data = 32'h0;
    settle("post_reset");
    send_bits(fr, FB - 1, 0, -1);
    expect_evt(K_LATCH, 8'h5C, 32'h01234567);
    settle("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
